// File: rtl/act_seq_pkg.sv
// -----------------------------------------------------------------------------
// act_seq_pkg
// Shared types and constants for the actuator sequencer:
//   state_e         - sequencer states SETTLE, IDLE, RELEASE, INSERT, FAULT
//   FLT_*           - fault_code encodings
//   EN_*            - one-hot enable vectors, bit order {release, insert, reset, alarm}
//   state_enables() - enable vector driven in a given state
// -----------------------------------------------------------------------------
package act_seq_pkg;

  typedef enum logic [2:0] {
    SETTLE  = 3'd0,
    IDLE    = 3'd1,
    RELEASE = 3'd2,
    INSERT  = 3'd3,
    FAULT   = 3'd4
  } state_e;

  localparam logic [1:0] FLT_NONE = 2'd0;
  localparam logic [1:0] FLT_TMO  = 2'd1;
  localparam logic [1:0] FLT_LIM  = 2'd2;
  localparam logic [1:0] FLT_EXT  = 2'd3;

  localparam logic [3:0] EN_RELEASE = 4'b1000;
  localparam logic [3:0] EN_INSERT  = 4'b0100;
  localparam logic [3:0] EN_RESET   = 4'b0010;
  localparam logic [3:0] EN_ALARM   = 4'b0001;

  // A move state in its retry pause cycle drives reset instead of its direction.
  function automatic logic [3:0] state_enables(input state_e st, input logic pause);
    logic [3:0] en;
    case (st)
      RELEASE: en = pause ? EN_RESET : EN_RELEASE;
      INSERT:  en = pause ? EN_RESET : EN_INSERT;
      FAULT:   en = EN_ALARM;
      default: en = EN_RESET;
    endcase
    return en;
  endfunction

endpackage

// File: rtl/act_seq_timer.sv
// -----------------------------------------------------------------------------
// act_seq_timer
// Clear/enable counter that saturates at MAX and never wraps. Used for both the
// settle interval and the move timeout.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   clr         - synchronous clear (wins over en)
//   en          - count enable
//   limit       - cycle count to flag (must be >= 1)
//   tc          - high in the cycle whose increment makes the count reach limit
// -----------------------------------------------------------------------------
module act_seq_timer #(
  parameter int unsigned MAX = 1000,
  parameter int unsigned W   = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic         tc
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: clear, saturating increment, or hold.
  always_comb begin
    if (clr) begin
      count_d = {W{1'b0}};
    end else if (en && (count_q < W'(MAX))) begin
      count_d = count_q + W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // count_q is the number of cycles already spent, so the flag fires on the limit-th cycle.
  assign tc = en && (count_q == (limit - W'(1)));

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= {W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/actuator_sequencer.sv
// -----------------------------------------------------------------------------
// actuator_sequencer
// Command-level controller for the release/insert actuator enable stage. Accepts
// one move at a time, drives exactly one of release/insert/reset/alarm, supervises
// moves with limit switches and a timeout, latches faults, and lets scram force
// an insert.
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   cmd_valid/cmd_dir     - move request (dir 1 = release, 0 = insert)
//   cmd_ready             - request accepted when cmd_valid & cmd_ready
//   scram                 - level, forces insert
//   lim_rel, lim_ins      - end-of-travel limit switches
//   fault_in, fault_clr   - external fault level, fault clear pulse
//   en_release/en_insert/en_reset/en_alarm - one-hot actuator enables
//   busy, done            - move in progress, one-cycle completion pulse
//   fault_code            - 0 none, 1 timeout, 2 both limits, 3 external
// Build option: define ACT_SEQ_RETRY_EN to retry a move once after its first
// timeout (one reset cycle, then the same direction again).
// -----------------------------------------------------------------------------
module actuator_sequencer
  import act_seq_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter int unsigned SETTLE_CYCLES  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  input  logic       cmd_dir,
  output logic       cmd_ready,
  input  logic       scram,
  input  logic       lim_rel,
  input  logic       lim_ins,
  input  logic       fault_in,
  input  logic       fault_clr,
  output logic       en_release,
  output logic       en_insert,
  output logic       en_reset,
  output logic       en_alarm,
  output logic       busy,
  output logic       done,
  output logic [1:0] fault_code
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  state_e      state_q, state_d;
  logic [1:0]  fault_code_q, fault_code_d;
  logic [3:0]  en_q, en_d;
  logic        busy_q, busy_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        done_q, done_d;
  logic        pause_s;
  logic        both_lim_s;
  logic        target_lim_s;
  logic        timer_clr_s;
  logic        timer_en_s;
  logic        timer_tc_s;
  logic [TW-1:0] timer_limit_s;
`ifdef ACT_SEQ_RETRY_EN
  logic        pause_q;
  logic        retry_used_q, retry_used_d;
`endif

  assign both_lim_s    = lim_rel && lim_ins;
  assign target_lim_s  = (state_q == RELEASE) ? lim_rel : lim_ins;
  assign timer_en_s    = (state_q != IDLE) && (state_q != FAULT);
  assign timer_limit_s = (state_q == SETTLE) ? TW'(SETTLE_CYCLES) : TW'(TIMEOUT_CYCLES);
`ifdef ACT_SEQ_RETRY_EN
  // Clear into the pause cycle and through it so the retry starts from zero.
  assign timer_clr_s   = (state_d != state_q) || pause_s || pause_q;
`else
  assign timer_clr_s   = (state_d != state_q) || pause_s;
`endif

  act_seq_timer #(
    .MAX (TIMEOUT_CYCLES),
    .W   (TW)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (timer_clr_s),
    .en    (timer_en_s),
    .limit (timer_limit_s),
    .tc    (timer_tc_s)
  );

  // Next state, fault latch and next registered outputs. Priority: fault > scram > limit > timeout.
  always_comb begin
    state_d      = state_q;
    fault_code_d = fault_code_q;
    done_d       = 1'b0;
    pause_s      = 1'b0;
    if (state_q == FAULT) begin
      if (fault_clr && !fault_in && !both_lim_s) begin
        state_d      = SETTLE;
        fault_code_d = FLT_NONE;
      end else begin
        state_d      = FAULT;
      end
    end else if (fault_in) begin
      state_d      = FAULT;
      fault_code_d = FLT_EXT;
    end else if (both_lim_s) begin
      state_d      = FAULT;
      fault_code_d = FLT_LIM;
    end else begin
      case (state_q)
        SETTLE: begin
          // A scram held through settle takes effect on exit, unless already inserted.
          if (timer_tc_s) begin
            state_d = (scram && !lim_ins) ? INSERT : IDLE;
          end else begin
            state_d = SETTLE;
          end
        end
        IDLE: begin
          if (scram) begin
            state_d = lim_ins ? IDLE : INSERT;
          end else if (cmd_valid && cmd_ready_q) begin
            if (cmd_dir ? lim_rel : lim_ins) begin
              done_d  = 1'b1;
              state_d = IDLE;
            end else begin
              state_d = cmd_dir ? RELEASE : INSERT;
            end
          end else begin
            state_d = IDLE;
          end
        end
        RELEASE, INSERT: begin
          if (scram && (state_q == RELEASE)) begin
            state_d = INSERT;
          end else if (target_lim_s) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else if (timer_tc_s) begin
`ifdef ACT_SEQ_RETRY_EN
            if (!retry_used_q) begin
              pause_s = 1'b1;
            end else begin
              state_d      = FAULT;
              fault_code_d = FLT_TMO;
            end
`else
            state_d      = FAULT;
            fault_code_d = FLT_TMO;
`endif
          end else begin
            state_d = state_q;
          end
        end
        default: begin
          state_d = SETTLE;
        end
      endcase
    end
`ifdef ACT_SEQ_RETRY_EN
    // The retry allowance belongs to one move; any state change resets it.
    retry_used_d = (state_d == state_q) && (retry_used_q || pause_s);
`endif
    en_d        = state_enables(state_d, pause_s);
    busy_d      = (state_d == RELEASE) || (state_d == INSERT);
    cmd_ready_d = (state_d == IDLE) && !scram;
  end

  // State, fault code and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= SETTLE;
      fault_code_q <= FLT_NONE;
      en_q         <= EN_RESET;
      busy_q       <= 1'b0;
      cmd_ready_q  <= 1'b0;
      done_q       <= 1'b0;
`ifdef ACT_SEQ_RETRY_EN
      pause_q      <= 1'b0;
      retry_used_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      fault_code_q <= fault_code_d;
      en_q         <= en_d;
      busy_q       <= busy_d;
      cmd_ready_q  <= cmd_ready_d;
      done_q       <= done_d;
`ifdef ACT_SEQ_RETRY_EN
      pause_q      <= pause_s;
      retry_used_q <= retry_used_d;
`endif
    end
  end

  assign en_release = en_q[3];
  assign en_insert  = en_q[2];
  assign en_reset   = en_q[1];
  assign en_alarm   = en_q[0];
  assign busy       = busy_q;
  assign cmd_ready  = cmd_ready_q;
  assign done       = done_q;
  assign fault_code = fault_code_q;

endmodule

// File: tb/tb_actuator_sequencer.sv
// -----------------------------------------------------------------------------
// tb_actuator_sequencer
// Directed bench for actuator_sequencer. Outputs are packed as
// {en_release, en_insert, en_reset, en_alarm, busy, cmd_ready, done, fault_code}
// and compared against hand-computed vectors one cycle at a time. The enables
// are also watched for one-hotness on every falling edge.
// -----------------------------------------------------------------------------
module tb_actuator_sequencer;

  localparam int TMO = 1000;

  localparam logic [3:0] E_REL = 4'b1000;
  localparam logic [3:0] E_INS = 4'b0100;
  localparam logic [3:0] E_RST = 4'b0010;
  localparam logic [3:0] E_ALM = 4'b0001;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_dir;
  logic       cmd_ready;
  logic       scram;
  logic       lim_rel;
  logic       lim_ins;
  logic       fault_in;
  logic       fault_clr;
  logic       en_release;
  logic       en_insert;
  logic       en_reset;
  logic       en_alarm;
  logic       busy;
  logic       done;
  logic [1:0] fault_code;
  logic [8:0] outs_s;

  int n_tests    = 0;
  int n_fail     = 0;
  int onehot_bad = 0;

  actuator_sequencer #(
    .TIMEOUT_CYCLES (TMO),
    .SETTLE_CYCLES  (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_dir    (cmd_dir),
    .cmd_ready  (cmd_ready),
    .scram      (scram),
    .lim_rel    (lim_rel),
    .lim_ins    (lim_ins),
    .fault_in   (fault_in),
    .fault_clr  (fault_clr),
    .en_release (en_release),
    .en_insert  (en_insert),
    .en_reset   (en_reset),
    .en_alarm   (en_alarm),
    .busy       (busy),
    .done       (done),
    .fault_code (fault_code)
  );

  always #5 clk = ~clk;

  assign outs_s = {en_release, en_insert, en_reset, en_alarm, busy, cmd_ready, done, fault_code};

  always @(negedge clk) begin
    if (!$onehot({en_release, en_insert, en_reset, en_alarm})) onehot_bad++;
  end

  function automatic logic [8:0] exp_v(input logic [3:0] en, input logic b, input logic r,
                                       input logic d, input logic [1:0] c);
    return {en, b, r, d, c};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_outs(input string tag, input logic [8:0] e);
    n_tests++;
    assert (outs_s === e) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, outs_s, e);
    end
  endtask

  task automatic expect_int(input string tag, input int obs, input int e);
    n_tests++;
    assert (obs === e) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, e);
    end
  endtask

  // Four settle cycles after reset or fault clear, then IDLE with ready.
  task automatic settle_to_idle(input string tag);
    repeat (3) tick();
    expect_outs({tag, "_settle"}, exp_v(E_RST, 1'b0, 1'b0, 1'b0, 2'd0));
    tick();
    expect_outs({tag, "_idle"}, exp_v(E_RST, 1'b0, 1'b1, 1'b0, 2'd0));
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_dir = 1'b0; scram = 1'b0;
    lim_rel = 1'b0; lim_ins = 1'b0; fault_in = 1'b0; fault_clr = 1'b0;
    tick(); tick();
    expect_outs("reset", exp_v(E_RST, 1'b0, 1'b0, 1'b0, 2'd0));
    rst_n = 1'b1;
    settle_to_idle("boot");

    // Release move completing on lim_rel in its 10th cycle.
    cmd_valid = 1'b1; cmd_dir = 1'b1; tick(); cmd_valid = 1'b0;
    expect_outs("rel_c1", exp_v(E_REL, 1'b1, 1'b0, 1'b0, 2'd0));
    repeat (9) tick();
    expect_outs("rel_c10", exp_v(E_REL, 1'b1, 1'b0, 1'b0, 2'd0));
    lim_rel = 1'b1; tick();
    expect_outs("rel_done", exp_v(E_RST, 1'b0, 1'b1, 1'b1, 2'd0));
    lim_rel = 1'b0; tick();
    expect_outs("rel_done_end", exp_v(E_RST, 1'b0, 1'b1, 1'b0, 2'd0));

    // Target limit already active: move skipped, done one cycle after handshake.
    lim_rel = 1'b1; cmd_valid = 1'b1; cmd_dir = 1'b1; tick(); cmd_valid = 1'b0;
    expect_outs("skip_done", exp_v(E_RST, 1'b0, 1'b1, 1'b1, 2'd0));
    lim_rel = 1'b0; tick();
    expect_outs("skip_end", exp_v(E_RST, 1'b0, 1'b1, 1'b0, 2'd0));

    // Scram in release cycle 5 aborts to insert without done.
    cmd_valid = 1'b1; cmd_dir = 1'b1; tick(); cmd_valid = 1'b0;
    repeat (4) tick();
    scram = 1'b1; tick();
    expect_outs("scram_ins", exp_v(E_INS, 1'b1, 1'b0, 1'b0, 2'd0));
    scram = 1'b0; repeat (3) tick();
    expect_outs("scram_hold", exp_v(E_INS, 1'b1, 1'b0, 1'b0, 2'd0));
    lim_ins = 1'b1; tick();
    expect_outs("scram_done", exp_v(E_RST, 1'b0, 1'b1, 1'b1, 2'd0));
    lim_ins = 1'b0;

    // Both limits while idle; clear ignored until one drops.
    lim_rel = 1'b1; lim_ins = 1'b1; tick();
    expect_outs("both_lim", exp_v(E_ALM, 1'b0, 1'b0, 1'b0, 2'd2));
    fault_clr = 1'b1; tick(); fault_clr = 1'b0;
    expect_outs("lim_clr_ignored", exp_v(E_ALM, 1'b0, 1'b0, 1'b0, 2'd2));
    lim_ins = 1'b0; tick();
    expect_outs("lim_fault_hold", exp_v(E_ALM, 1'b0, 1'b0, 1'b0, 2'd2));
    fault_clr = 1'b1; tick(); fault_clr = 1'b0;
    expect_outs("lim_clr", exp_v(E_RST, 1'b0, 1'b0, 1'b0, 2'd0));
    lim_rel = 1'b0;
    settle_to_idle("lim");

    // Insert with no limit: timeout fault after 1000 cycles (retry build: twice).
    cmd_valid = 1'b1; cmd_dir = 1'b0; tick(); cmd_valid = 1'b0;
    expect_outs("ins_c1", exp_v(E_INS, 1'b1, 1'b0, 1'b0, 2'd0));
    repeat (TMO - 1) tick();
    expect_outs("ins_c1000", exp_v(E_INS, 1'b1, 1'b0, 1'b0, 2'd0));
    tick();
`ifdef ACT_SEQ_RETRY_EN
    expect_outs("retry_pause", exp_v(E_RST, 1'b1, 1'b0, 1'b0, 2'd0));
    tick();
    expect_outs("retry_c1", exp_v(E_INS, 1'b1, 1'b0, 1'b0, 2'd0));
    repeat (TMO - 1) tick();
    expect_outs("retry_c1000", exp_v(E_INS, 1'b1, 1'b0, 1'b0, 2'd0));
    tick();
`endif
    expect_outs("tmo_fault", exp_v(E_ALM, 1'b0, 1'b0, 1'b0, 2'd1));
    fault_clr = 1'b1; tick(); fault_clr = 1'b0;
    expect_outs("tmo_clr", exp_v(E_RST, 1'b0, 1'b0, 1'b0, 2'd0));
    settle_to_idle("tmo");

    // External fault in the timeout cycle wins; clear ignored while fault_in high.
    cmd_valid = 1'b1; cmd_dir = 1'b0; tick(); cmd_valid = 1'b0;
    repeat (TMO - 1) tick();
`ifdef ACT_SEQ_RETRY_EN
    tick(); tick();
    repeat (TMO - 1) tick();
`endif
    fault_in = 1'b1; tick();
    expect_outs("ext_over_tmo", exp_v(E_ALM, 1'b0, 1'b0, 1'b0, 2'd3));
    fault_clr = 1'b1; tick(); fault_clr = 1'b0;
    expect_outs("ext_clr_ignored", exp_v(E_ALM, 1'b0, 1'b0, 1'b0, 2'd3));
    fault_in = 1'b0; fault_clr = 1'b1; tick(); fault_clr = 1'b0;
    expect_outs("ext_clr", exp_v(E_RST, 1'b0, 1'b0, 1'b0, 2'd0));
    settle_to_idle("ext");

    // Fault and scram together: alarm wins.
    scram = 1'b1; fault_in = 1'b1; tick();
    expect_outs("fault_over_scram", exp_v(E_ALM, 1'b0, 1'b0, 1'b0, 2'd3));
    scram = 1'b0; fault_in = 1'b0; fault_clr = 1'b1; tick(); fault_clr = 1'b0;
    settle_to_idle("fs");

    // Asynchronous reset in the middle of an insert.
    cmd_valid = 1'b1; cmd_dir = 1'b0; tick(); cmd_valid = 1'b0;
    repeat (3) tick();
    expect_outs("ins_mid", exp_v(E_INS, 1'b1, 1'b0, 1'b0, 2'd0));
    #2; rst_n = 1'b0; #1;
    expect_outs("async_rst", exp_v(E_RST, 1'b0, 1'b0, 1'b0, 2'd0));
    tick(); rst_n = 1'b1;

    // Scram held through settle is honoured on exit.
    scram = 1'b1;
    repeat (3) tick();
    expect_outs("scram_settle", exp_v(E_RST, 1'b0, 1'b0, 1'b0, 2'd0));
    tick();
    expect_outs("scram_settle_exit", exp_v(E_INS, 1'b1, 1'b0, 1'b0, 2'd0));
    scram = 1'b0; lim_ins = 1'b1; tick();
    expect_outs("scram_settle_done", exp_v(E_RST, 1'b0, 1'b1, 1'b1, 2'd0));
    lim_ins = 1'b0; tick();

    expect_int("onehot", onehot_bad, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
